logic_op_arbiter: RTL and testbench

//  Shares one combinational bitwise logic unit (AND/OR/XOR/XNOR) between NREQ requesters.
//  A round-robin arbiter picks one pending request, the shared unit computes it, and the

---
 rtl/logic_op_pkg.sv | 13 +
 rtl/logic_op_unit.sv | 17 +
 rtl/logic_op_arbiter.sv | 82 ++++++++
 tb/tb_logic_op_arbiter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/logic_op_pkg.sv
// logic_op_pkg: shared op encoding and response-slot state for the logic-op arbiter.
package logic_op_pkg;
    typedef enum logic [1:0] {
        OP_AND  = 2'd0,
        OP_OR   = 2'd1,
        OP_XOR  = 2'd2,
        OP_XNOR = 2'd3
    } op_e;
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;
endpackage

// File: rtl/logic_op_unit.sv
// logic_op_unit: combinational bitwise AND/OR/XOR/XNOR of two WIDTH-bit operands.
module logic_op_unit
    import logic_op_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  op_e              op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] y_o
);
    always_comb begin
        y_o = op_i == OP_AND ? a_i & b_i :
              op_i == OP_OR  ? a_i | b_i :
              op_i == OP_XOR ? a_i ^ b_i : ~(a_i ^ b_i);
    end
endmodule

// File: rtl/logic_op_arbiter.sv
// logic_op_arbiter: round-robin sharing of one logic_op_unit among NREQ requesters,
// with a single registered result slot returned over a valid/ready port.
module logic_op_arbiter
    import logic_op_pkg::*;
#(
    parameter  int NREQ  = 4,
    parameter  int WIDTH = 8,
    localparam int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [2*NREQ-1:0]     req_op,
    input  logic [WIDTH*NREQ-1:0] req_a,
    input  logic [WIDTH*NREQ-1:0] req_b,
    output logic [NREQ-1:0]       req_ready,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_data,
    output logic                  busy
);
    state_e           state_q, state_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]   id_q;
    logic [WIDTH-1:0] data_q;
    logic [IDW-1:0]   win_id;
    logic             found;
    logic             accept;
    op_e              win_op;
    logic [WIDTH-1:0] win_a, win_b, win_y;

    // Scan from rr_ptr upward, wrapping at NREQ so non-power-of-2 counts never overflow.
    always_comb begin
        found  = 1'b0;
        win_id = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && req_valid[(int'(rr_ptr_q) + k) % NREQ]) begin
                found  = 1'b1;
                win_id = IDW'((int'(rr_ptr_q) + k) % NREQ);
            end
        end
    end

    always_comb begin
        accept    = found && (state_q == EMPTY || rsp_ready) && !rst;
        req_ready = accept ? NREQ'(1) << win_id : '0;
        rr_ptr_d  = win_id == IDW'(NREQ - 1) ? '0 : win_id + 1'b1;
        win_op    = op_e'(req_op[2*win_id +: 2]);
        win_a     = req_a[WIDTH*win_id +: WIDTH];
        win_b     = req_b[WIDTH*win_id +: WIDTH];
        state_d   = accept ? FULL : (state_q == FULL && rsp_ready) ? EMPTY : state_q;
    end

    logic_op_unit #(.WIDTH(WIDTH)) u_unit (
        .op_i(win_op),
        .a_i (win_a),
        .b_i (win_b),
        .y_o (win_y)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= EMPTY;
            rr_ptr_q <= '0;
            id_q     <= '0;
            data_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                rr_ptr_q <= rr_ptr_d;
                id_q     <= win_id;
                data_q   <= win_y;
            end
        end
    end

    assign rsp_valid = state_q == FULL;
    assign rsp_id    = id_q;
    assign rsp_data  = data_q;
    assign busy      = rsp_valid;
endmodule

// File: tb/tb_logic_op_arbiter.sv
// tb_logic_op_arbiter: directed scenarios plus a random run, all backed by a
// reference model of the arbiter and a scoreboard of expected responses.
module tb_logic_op_arbiter;
    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int IDW   = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       v;
    logic [1:0]            op [NREQ];
    logic [WIDTH-1:0]      a [NREQ];
    logic [WIDTH-1:0]      b [NREQ];
    logic                  rsp_ready;
    logic [2*NREQ-1:0]     req_op;
    logic [WIDTH*NREQ-1:0] req_a, req_b;
    logic [NREQ-1:0]       req_ready;
    logic                  rsp_valid;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      rsp_data;
    logic                  busy;

    int errors = 0;
    int checks = 0;
    logic [IDW+WIDTH-1:0] sb [$];
    logic                 m_valid = 1'b0;
    int                   m_ptr = 0;
    logic [NREQ-1:0]      last_rdy;

    always #5 clk = ~clk;

    always_comb begin
        req_op = '0;
        req_a  = '0;
        req_b  = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_op[2*i +: 2]         = op[i];
            req_a[WIDTH*i +: WIDTH]  = a[i];
            req_b[WIDTH*i +: WIDTH]  = b[i];
        end
    end

    logic_op_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .req_valid(v), .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy)
    );

    function automatic logic [WIDTH-1:0] golden(input logic [1:0] o, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        case (o)
            2'd0:    return x & y;
            2'd1:    return x | y;
            2'd2:    return x ^ y;
            default: return ~(x ^ y);
        endcase
    endfunction

    // Model check of grant/valid/response, then advance the model as the edge will.
    task automatic monitor();
        logic [NREQ-1:0] er;
        logic            fnd;
        int              w;
        er = '0; fnd = 1'b0; w = 0;
        for (int k = 0; k < NREQ; k++)
            if (!fnd && v[(m_ptr + k) % NREQ]) begin fnd = 1'b1; w = (m_ptr + k) % NREQ; end
        if (fnd && (!m_valid || rsp_ready) && !rst) er[w] = 1'b1;
        checks++;
        if (req_ready !== er) begin errors++; $display("FAIL grant: req_ready=%b expected %b", req_ready, er); end
        checks++;
        if (rsp_valid !== m_valid || busy !== m_valid) begin
            errors++; $display("FAIL valid: rsp_valid=%b busy=%b expected %b", rsp_valid, busy, m_valid);
        end
        if (m_valid) begin
            checks++;
            if (sb.size() == 0) begin errors++; $display("FAIL scoreboard: response present but nothing expected"); end
            else if ({rsp_id, rsp_data} !== sb[0]) begin
                errors++; $display("FAIL response: id=%0d data=%h expected id=%0d data=%h", rsp_id, rsp_data, sb[0][WIDTH +: IDW], sb[0][WIDTH-1:0]);
            end
            if (rsp_ready && sb.size() > 0) void'(sb.pop_front());
        end
        last_rdy = req_ready;
        if (rst) begin
            m_valid = 1'b0; m_ptr = 0; sb.delete();
        end else if (er != '0) begin
            sb.push_back({IDW'(w), golden(op[w], a[w], b[w])});
            m_ptr = (w + 1) % NREQ; m_valid = 1'b1;
        end else if (m_valid && rsp_ready) m_valid = 1'b0;
    endtask

    task automatic sample(); @(negedge clk); monitor(); endtask
    task automatic tick();   @(posedge clk); #1;        endtask

    task automatic test_reset();
        rst = 1'b1; v = '1; rsp_ready = 1'b1;
        repeat (2) begin
            sample();
            checks++;
            if (req_ready !== 4'b0 || rsp_valid !== 1'b0 || rsp_data !== 8'h00) begin
                errors++; $display("FAIL reset: req_ready=%b rsp_valid=%b rsp_data=%h expected 0/0/00", req_ready, rsp_valid, rsp_data);
            end
            tick();
        end
        rst = 1'b0; v = '0;
    endtask

    task automatic test_single();
        v = 4'b0010; op[1] = 2'd2; a[1] = 8'hF0; b[1] = 8'hAA; rsp_ready = 1'b1;
        sample();
        checks++;
        if (req_ready !== 4'b0010) begin errors++; $display("FAIL single_grant: req_ready=%b expected 0010", req_ready); end
        tick(); v = '0;
        sample();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== 8'h5A) begin
            errors++; $display("FAIL single_rsp: valid=%b id=%0d data=%h expected 1/1/5a", rsp_valid, rsp_id, rsp_data);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_d [4];
        exp_d = '{8'h84, 8'hED, 8'h69, 8'h96};
        rst = 1'b1; sample(); tick(); rst = 1'b0;
        for (int i = 0; i < NREQ; i++) begin op[i] = 2'(i); a[i] = 8'hCC; b[i] = 8'hA5; end
        v = '1; rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            sample();
            checks++;
            if (req_ready !== 4'(1 << (k % 4))) begin errors++; $display("FAIL rr_grant%0d: req_ready=%b expected %b", k, req_ready, 4'(1 << (k % 4))); end
            if (k > 0) begin
                checks++;
                if (rsp_id !== 2'((k - 1) % 4) || rsp_data !== exp_d[(k - 1) % 4]) begin
                    errors++; $display("FAIL rr_data%0d: id=%0d data=%h expected id=%0d data=%h", k, rsp_id, rsp_data, (k - 1) % 4, exp_d[(k - 1) % 4]);
                end
            end
            tick();
        end
        v = '0;
        sample();
        checks++;
        if (rsp_id !== 2'd0 || rsp_data !== 8'h84) begin errors++; $display("FAIL rr_last: id=%0d data=%h expected 0/84", rsp_id, rsp_data); end
        tick();
    endtask

    task automatic test_backpressure();
        v = 4'b0100; rsp_ready = 1'b1;
        sample();
        checks++;
        if (req_ready !== 4'b0100) begin errors++; $display("FAIL bp_grant: req_ready=%b expected 0100", req_ready); end
        tick();
        v = 4'b0001; rsp_ready = 1'b0;
        repeat (3) begin
            sample();
            checks++;
            if (req_ready !== 4'b0 || rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_data !== 8'h69) begin
                errors++; $display("FAIL bp_hold: req_ready=%b valid=%b id=%0d data=%h expected 0000/1/2/69", req_ready, rsp_valid, rsp_id, rsp_data);
            end
            tick();
        end
        rsp_ready = 1'b1;
        sample();
        checks++;
        if (req_ready !== 4'b0001) begin errors++; $display("FAIL bp_release: req_ready=%b expected 0001", req_ready); end
        tick(); v = '0;
        sample();
        checks++;
        if (rsp_id !== 2'd0 || rsp_data !== 8'h84) begin errors++; $display("FAIL bp_next: id=%0d data=%h expected 0/84", rsp_id, rsp_data); end
        tick();
    endtask

    task automatic test_reset_mid();
        v = 4'b0001; rsp_ready = 1'b0;
        sample(); tick();
        v = '0; rst = 1'b1;
        sample(); tick();
        rst = 1'b0; rsp_ready = 1'b1;
        sample();
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_mid: rsp_valid=%b expected 0", rsp_valid); end
        tick();
        v = 4'b1001;
        sample();
        checks++;
        if (req_ready !== 4'b0001) begin errors++; $display("FAIL rst_ptr: req_ready=%b expected 0001", req_ready); end
        tick(); v = '0;
        sample(); tick();
    endtask

    task automatic test_wrap();
        v = 4'b1000; rsp_ready = 1'b1;
        sample();
        checks++;
        if (req_ready !== 4'b1000) begin errors++; $display("FAIL wrap_grant3: req_ready=%b expected 1000", req_ready); end
        tick();
        v = 4'b1010;
        sample();
        checks++;
        if (req_ready !== 4'b0010) begin errors++; $display("FAIL wrap_grant1: req_ready=%b expected 0010", req_ready); end
        tick(); v = '0;
        sample(); tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            sample(); tick();
            for (int i = 0; i < NREQ; i++)
                if (!v[i] || last_rdy[i]) begin
                    v[i] = 1'($urandom_range(0, 1));
                    op[i] = 2'($urandom_range(0, 3));
                    a[i] = 8'($urandom);
                    b[i] = 8'($urandom);
                end
            rsp_ready = $urandom_range(0, 3) != 0;
        end
        v = '0; rsp_ready = 1'b1;
        repeat (3) begin sample(); tick(); end
        checks++;
        if (sb.size() != 0 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL drain: pending=%0d rsp_valid=%b expected 0/0", sb.size(), rsp_valid);
        end
    endtask

    initial begin
        rst = 1'b1; v = '0; rsp_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) begin op[i] = '0; a[i] = '0; b[i] = '0; end
        @(posedge clk); #1;
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
